vga_sync_gen: RTL

- Free-running VGA timing generator. Produces hsync/vsync, a display-active flag, pixel coordinates and line/frame start strobes.
- Sits directly upstream of the goose sprite/colour logic inside tt_um_oiia_goose. That logic consumes hpos/vpos/display_on to form RGB, and the top packs hsync/vsync with RGB onto uo_out for the TinyVGA PMOD.
- Default timing: 640x480@60 from the 25 MHz TT clock.

---
 rtl/vga_sync_gen_if.sv | 18 +
 rtl/vga_sync_gen.sv | 86 ++++++++
 2 files changed

// File: rtl/vga_sync_gen_if.sv
// Output bundle of the VGA timing generator: pixel position, blanking, syncs and strobes.
interface vga_sync_gen_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;

  modport master (
    output hpos, vpos, display_on, hsync, vsync, line_start, frame_start
  );

  modport slave (
    input hpos, vpos, display_on, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator (default 640x480@60 from a 25 MHz pixel clock).
// Every output is registered alongside the counters, so all outputs describe the current (hpos, vpos).
module vga_sync_gen #(
  parameter int H_DISPLAY       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_DISPLAY       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [9:0]  HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]  HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]  VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic        SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  logic [9:0] hpos_q, vpos_q;
  logic       display_on_q, hsync_q, vsync_q, line_start_q, frame_start_q;

  logic [9:0] hpos_d, vpos_d;
  logic       display_on_d, hsync_d, vsync_d, line_start_d, frame_start_d;
  logic       h_wrap;

  // Flags are derived from the next position so they land in the same register update.
  always_comb begin
    h_wrap        = (hpos_q == H_LAST);
    hpos_d        = h_wrap ? 10'd0 : hpos_q + 10'd1;
    vpos_d        = vpos_q;
    if (h_wrap) begin
      vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
    end
    display_on_d  = ({1'b0, hpos_d} < H_VIS) && ({1'b0, vpos_d} < V_VIS);
    hsync_d       = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
    vsync_d       = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
    line_start_d  = (hpos_d == 10'd0);
    frame_start_d = (hpos_d == 10'd0) && (vpos_d == 10'd0);
  end

  // Reset parks on the last blanking pixel of a frame so the first enabled edge starts frame 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      display_on_q  <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (ena) begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      display_on_q  <= display_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.display_on  = display_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
endmodule
